// File: rtl/montgomery_ctrl.sv
// Montgomery product controller: computes A*B*2^-512 mod M bit-serially,
// issuing one add/add-shift per bit of A through an external 514-bit adder.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   start               request one product (sampled only in IDLE)
//   in_a, in_b, in_m    512-bit operands, latched on an accepted start
//   result, done, busy  product, one-cycle completion pulse, activity flag
//   add_start           one-cycle strobe issuing an adder operation
//   add_subtract        adder mode: in_a - in_b
//   add_shift           adder mode: (in_a + in_b) >> 1
//   add_in_a, add_in_b  adder operands, held until add_done is sampled
//   add_result          adder output; bit 514 flags a negative subtract
//   add_done            adder result valid (sampled only in WAIT states)

module montgomery_ctrl (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [511:0] in_a,
    input  logic [511:0] in_b,
    input  logic [511:0] in_m,
    output logic [511:0] result,
    output logic         done,
    output logic         busy,
    output logic         add_start,
    output logic         add_subtract,
    output logic         add_shift,
    output logic [513:0] add_in_a,
    output logic [513:0] add_in_b,
    input  logic [514:0] add_result,
    input  logic         add_done
);

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        ADD_B,
        WAIT_B,
        ADD_M,
        WAIT_M,
        SUB,
        WAIT_SUB,
        DONE
    } state_t;

    state_t       state_q, state_d;
    logic [511:0] a_q, a_d;
    logic [511:0] b_q, b_d;
    logic [511:0] m_q, m_d;
    logic [513:0] c_q, c_d;
    logic [8:0]   i_q, i_d;
    logic [511:0] result_q, result_d;
    logic [8:0]   i_inc;

    assign i_inc = i_q + 9'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            c_q      <= '0;
            i_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            c_q      <= c_d;
            i_q      <= i_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        c_d      = c_q;
        i_d      = i_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    m_d     = in_m;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                c_d     = '0;
                i_d     = '0;
                state_d = a_q[0] ? ADD_B : ADD_M;
            end
            ADD_B: state_d = WAIT_B;
            WAIT_B: begin
                if (add_done) begin
                    c_d     = add_result[513:0];
                    state_d = ADD_M;
                end
            end
            ADD_M: state_d = WAIT_M;
            WAIT_M: begin
                if (add_done) begin
                    c_d = add_result[513:0];
                    if (i_q == 9'd511) begin
                        state_d = SUB;
                    end else begin
                        i_d     = i_inc;
                        state_d = a_q[i_inc] ? ADD_B : ADD_M;
                    end
                end
            end
            SUB: state_d = WAIT_SUB;
            WAIT_SUB: begin
                if (add_done) begin
                    // C < 2M, so one conditional subtract fully reduces it
                    result_d = add_result[514] ? c_q[511:0]
                                               : add_result[511:0];
                    state_d  = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operands are decoded from state and C; C only changes when add_done
    // is taken, so they stay stable across each ADD/WAIT pair.
    always_comb begin
        add_start    = 1'b0;
        add_subtract = 1'b0;
        add_shift    = 1'b0;
        add_in_a     = '0;
        add_in_b     = '0;
        done         = (state_q == DONE);
        busy         = (state_q != IDLE);
        result       = result_q;
        unique case (state_q)
            ADD_B, WAIT_B: begin
                add_start = (state_q == ADD_B);
                add_in_a  = c_q;
                add_in_b  = {2'b00, b_q};
            end
            ADD_M, WAIT_M: begin
                add_start = (state_q == ADD_M);
                add_shift = 1'b1;
                add_in_a  = c_q;
                add_in_b  = c_q[0] ? {2'b00, m_q} : '0;
            end
            SUB, WAIT_SUB: begin
                add_start    = (state_q == SUB);
                add_subtract = 1'b1;
                add_in_a     = c_q;
                add_in_b     = {2'b00, m_q};
            end
            default: ;
        endcase
    end

endmodule
